axi_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one AXI write path (AW, W, B) among NumMasters requesters.
- Sits upstream of the clock-crossing AXI transactor.
- One burst is granted at a time. The W channel is locked to the granted master until the wlast handshake.
- The grant index is carried in the upper AWID bits so that B responses route back to the correct requester.

---
 rtl/axi_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/axi_wr_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_axi_wr_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI write-path arbiter: FSM states, AXI field widths,
// the muxed AW attribute bundle and a modulo increment helper.
package axi_arb_pkg;

    typedef enum logic [1:0] {IDLE, AW, W} arb_state_e;

    localparam int unsigned AddrWidth  = 32;
    localparam int unsigned LenWidth   = 8;
    localparam int unsigned SizeWidth  = 3;
    localparam int unsigned BurstWidth = 2;
    localparam int unsigned RespWidth  = 2;

    typedef struct packed {
        logic [AddrWidth-1:0]  addr;
        logic [LenWidth-1:0]   len;
        logic [SizeWidth-1:0]  size;
        logic [BurstWidth-1:0] burst;
    } aw_fields_t;

    // v + 1 wrapped modulo n
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or above i_ptr,
// wrapping modulo NumMasters. Shared between the AW and AR arbiters.
module rr_arbiter #(
    parameter int unsigned  NumMasters = 4,
    localparam int unsigned IdxWidth   = $clog2(NumMasters)
) (
    input  logic [NumMasters-1:0] i_req,
    input  logic [IdxWidth-1:0]   i_ptr,
    output logic [IdxWidth-1:0]   o_grant,
    output logic                  o_any_req
);

    int unsigned          w_pos;
    logic [IdxWidth-1:0]  w_sel;

    // Scan from farthest to nearest so the nearest requester overwrites last
    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        w_pos     = 0;
        w_sel     = '0;
        for (int unsigned k = 0; k < NumMasters; k++) begin
            w_pos = (32'(i_ptr) + NumMasters - 1 - k) % NumMasters;
            w_sel = w_pos[IdxWidth-1:0];
            if (i_req[w_sel]) begin
                o_grant   = w_sel;
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write path (AW, W, B) among NumMasters.
// One burst in flight at a time; W is locked to the granted master until wlast.
// The grant index rides in the upper AWID bits so B responses route back.
// Optional watchdog on stalled W bursts: define AXI_WR_ARB_WDOG_EN.
module axi_wr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int unsigned  NumMasters  = 4,
    parameter int unsigned  AxiBusWidth = 128,
    parameter int unsigned  IdWidth     = 4,
`ifdef AXI_WR_ARB_WDOG_EN
    parameter int unsigned  WdogCycles  = 256,
`endif
    localparam int unsigned IdxWidth    = $clog2(NumMasters)
) (
    input  logic                                  wclk_i,
    input  logic                                  rrst_n,
    input  logic [NumMasters-1:0]                 s_awvalid,
    output logic [NumMasters-1:0]                 s_awready,
    input  logic [NumMasters*AddrWidth-1:0]       s_awaddr,
    input  logic [NumMasters*IdWidth-1:0]         s_awid,
    input  logic [NumMasters*LenWidth-1:0]        s_awlen,
    input  logic [NumMasters*SizeWidth-1:0]       s_awsize,
    input  logic [NumMasters*BurstWidth-1:0]      s_awburst,
    input  logic [NumMasters-1:0]                 s_wvalid,
    output logic [NumMasters-1:0]                 s_wready,
    input  logic [NumMasters*AxiBusWidth-1:0]     s_wdata,
    input  logic [NumMasters*AxiBusWidth/8-1:0]   s_wstrb,
    input  logic [NumMasters-1:0]                 s_wlast,
    output logic [NumMasters-1:0]                 s_bvalid,
    input  logic [NumMasters-1:0]                 s_bready,
    output logic [IdWidth-1:0]                    s_bid,
    output logic [RespWidth-1:0]                  s_bresp,
    output logic                                  m_awvalid,
    input  logic                                  m_awready,
    output logic [AddrWidth-1:0]                  m_awaddr,
    output logic [LenWidth-1:0]                   m_awlen,
    output logic [SizeWidth-1:0]                  m_awsize,
    output logic [BurstWidth-1:0]                 m_awburst,
    output logic [IdxWidth+IdWidth-1:0]           m_awid,
    output logic                                  m_wvalid,
    input  logic                                  m_wready,
    output logic [AxiBusWidth-1:0]                m_wdata,
    output logic [AxiBusWidth/8-1:0]              m_wstrb,
    output logic                                  m_wlast,
    input  logic                                  m_bvalid,
    output logic                                  m_bready,
    input  logic [IdxWidth+IdWidth-1:0]           m_bid,
    input  logic [RespWidth-1:0]                  m_bresp,
`ifdef AXI_WR_ARB_WDOG_EN
    output logic                                  wdog_err_o,
`endif
    output logic [IdxWidth-1:0]                   grant_o
);

    localparam int unsigned StrbWidth = AxiBusWidth / 8;

    arb_state_e           r_state, w_state_d;
    logic [IdxWidth-1:0]  r_grant, w_grant_d;
    logic [IdxWidth-1:0]  r_rr_ptr, w_rr_ptr_d;
    logic [IdxWidth-1:0]  w_arb_grant;
    logic [IdxWidth-1:0]  w_ptr_inc;
    logic [IdxWidth-1:0]  w_bidx;
    logic                 w_any_req;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    aw_fields_t           w_aw;
    logic [IdWidth-1:0]   w_awid;
`ifdef AXI_WR_ARB_WDOG_EN
    logic [15:0]          r_wdog_cnt, w_wdog_cnt_d;
    logic                 r_wdog_err, w_wdog_err_d;
`endif

    rr_arbiter #(
        .NumMasters (NumMasters)
    ) u_rr_arbiter (
        .i_req     (s_awvalid),
        .i_ptr     (r_rr_ptr),
        .o_grant   (w_arb_grant),
        .o_any_req (w_any_req)
    );

    assign w_ptr_inc = IdxWidth'(wrap_inc(32'(r_grant), NumMasters));
    assign w_aw_hs   = m_awvalid & m_awready;
    assign w_w_hs    = m_wvalid & m_wready;
    assign grant_o   = r_grant;

    // Granted master's AW and W fields, muxed straight through
    always_comb begin
        w_aw.addr  = s_awaddr[32'(r_grant)*AddrWidth +: AddrWidth];
        w_aw.len   = s_awlen[32'(r_grant)*LenWidth +: LenWidth];
        w_aw.size  = s_awsize[32'(r_grant)*SizeWidth +: SizeWidth];
        w_aw.burst = s_awburst[32'(r_grant)*BurstWidth +: BurstWidth];
        w_awid     = s_awid[32'(r_grant)*IdWidth +: IdWidth];
        m_awaddr   = w_aw.addr;
        m_awlen    = w_aw.len;
        m_awsize   = w_aw.size;
        m_awburst  = w_aw.burst;
        m_awid     = {r_grant, w_awid};
        m_wdata    = s_wdata[32'(r_grant)*AxiBusWidth +: AxiBusWidth];
        m_wstrb    = s_wstrb[32'(r_grant)*StrbWidth +: StrbWidth];
        m_wlast    = s_wlast[r_grant];
    end

    // Handshake routing: only the granted master sees ready, only in its phase
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        case (r_state)
            AW: begin
                m_awvalid          = s_awvalid[r_grant];
                s_awready[r_grant] = m_awready;
            end
            W: begin
                m_wvalid          = s_wvalid[r_grant];
                s_wready[r_grant] = m_wready;
            end
            default: ;
        endcase
    end

    // Next-state: arbitrate in IDLE, pass AW, hold W until wlast (or watchdog)
    always_comb begin
        w_state_d  = r_state;
        w_grant_d  = r_grant;
        w_rr_ptr_d = r_rr_ptr;
`ifdef AXI_WR_ARB_WDOG_EN
        w_wdog_cnt_d = w_w_hs ? '0 : r_wdog_cnt + 16'd1;
        w_wdog_err_d = r_wdog_err;
`endif
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_d = w_arb_grant;
                    w_state_d = AW;
                end
            end
            AW: begin
`ifdef AXI_WR_ARB_WDOG_EN
                w_wdog_cnt_d = '0;
`endif
                if (w_aw_hs) begin
                    w_state_d = W;
                end
            end
            W: begin
                if (w_w_hs && m_wlast) begin
                    w_rr_ptr_d = w_ptr_inc;
                    w_state_d  = IDLE;
                end
`ifdef AXI_WR_ARB_WDOG_EN
                // Abandon the rest of a burst that stalls WdogCycles cycles
                else if (!w_w_hs && r_wdog_cnt == 16'(WdogCycles - 1)) begin
                    w_wdog_err_d = 1'b1;
                    w_rr_ptr_d   = w_ptr_inc;
                    w_state_d    = IDLE;
                end
`endif
            end
            default: w_state_d = IDLE;
        endcase
    end

    // State registers, synchronous active-low reset
    always_ff @(posedge wclk_i) begin
        if (!rrst_n) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
`ifdef AXI_WR_ARB_WDOG_EN
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_d;
            r_grant  <= w_grant_d;
            r_rr_ptr <= w_rr_ptr_d;
`ifdef AXI_WR_ARB_WDOG_EN
            r_wdog_cnt <= w_wdog_cnt_d;
            r_wdog_err <= w_wdog_err_d;
`endif
        end
    end

`ifdef AXI_WR_ARB_WDOG_EN
    assign wdog_err_o = r_wdog_err;
`endif

    // B return routing by the index carried in the top ID bits; stray IDs are sunk
    always_comb begin
        w_bidx   = m_bid[IdxWidth+IdWidth-1 -: IdxWidth];
        s_bvalid = '0;
        m_bready = 1'b1;
        if (32'(w_bidx) < NumMasters) begin
            s_bvalid[w_bidx] = m_bvalid;
            m_bready         = s_bready[w_bidx];
        end
        s_bid   = m_bid[IdWidth-1:0];
        s_bresp = m_bresp;
    end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Self-checking bench for axi_wr_arbiter: directed timing/ordering cases plus
// randomized bursts checked against a transaction-level round-robin model.
module tb_axi_wr_arbiter;

    localparam int NM = 4;
    localparam int BW = 128;
    localparam int SW = BW / 8;
    localparam int IW = 4;

    logic wclk_i = 1'b0;
    logic rrst_n = 1'b0;
    always #5 wclk_i = ~wclk_i;

    logic [NM-1:0]      s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic [NM*32-1:0]   s_awaddr;
    logic [NM*IW-1:0]   s_awid;
    logic [NM*8-1:0]    s_awlen;
    logic [NM*3-1:0]    s_awsize;
    logic [NM*2-1:0]    s_awburst;
    logic [NM*BW-1:0]   s_wdata;
    logic [NM*SW-1:0]   s_wstrb;
    logic [IW-1:0]      s_bid;
    logic [1:0]         s_bresp, m_bresp, m_awburst;
    logic               m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [31:0]        m_awaddr;
    logic [7:0]         m_awlen;
    logic [2:0]         m_awsize;
    logic [5:0]         m_awid, m_bid;
    logic [BW-1:0]      m_wdata;
    logic [SW-1:0]      m_wstrb;
    logic [1:0]         grant_o;
`ifdef AXI_WR_ARB_WDOG_EN
    logic               wdog_err_o, b3_wdog_err;
`endif

    axi_wr_arbiter #(.NumMasters(NM), .AxiBusWidth(BW), .IdWidth(IW)) dut (
        .wclk_i(wclk_i), .rrst_n(rrst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid),
        .s_bresp(s_bresp), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid),
        .m_bresp(m_bresp),
`ifdef AXI_WR_ARB_WDOG_EN
        .wdog_err_o(wdog_err_o),
`endif
        .grant_o(grant_o)
    );

    // Three-master instance: index 3 in the returned ID is out of range
    logic [2:0]  b3_awready, b3_wready, b3_s_bvalid, b3_s_bready;
    logic [3:0]  b3_s_bid;
    logic [1:0]  b3_s_bresp, b3_m_bresp, b3_awburst, b3_grant;
    logic        b3_awvalid, b3_wvalid, b3_wlast, b3_m_bvalid, b3_m_bready;
    logic [31:0] b3_awaddr, b3_wdata;
    logic [7:0]  b3_awlen;
    logic [2:0]  b3_awsize;
    logic [5:0]  b3_awid, b3_m_bid;
    logic [3:0]  b3_wstrb;

    axi_wr_arbiter #(.NumMasters(3), .AxiBusWidth(32), .IdWidth(4)) dut3 (
        .wclk_i(wclk_i), .rrst_n(rrst_n),
        .s_awvalid(3'b000), .s_awready(b3_awready), .s_awaddr(96'd0), .s_awid(12'd0),
        .s_awlen(24'd0), .s_awsize(9'd0), .s_awburst(6'd0),
        .s_wvalid(3'b000), .s_wready(b3_wready), .s_wdata(96'd0), .s_wstrb(12'd0),
        .s_wlast(3'b000), .s_bvalid(b3_s_bvalid), .s_bready(b3_s_bready), .s_bid(b3_s_bid),
        .s_bresp(b3_s_bresp), .m_awvalid(b3_awvalid), .m_awready(1'b0), .m_awaddr(b3_awaddr),
        .m_awlen(b3_awlen), .m_awsize(b3_awsize), .m_awburst(b3_awburst), .m_awid(b3_awid),
        .m_wvalid(b3_wvalid), .m_wready(1'b0), .m_wdata(b3_wdata), .m_wstrb(b3_wstrb),
        .m_wlast(b3_wlast), .m_bvalid(b3_m_bvalid), .m_bready(b3_m_bready), .m_bid(b3_m_bid),
        .m_bresp(b3_m_bresp),
`ifdef AXI_WR_ARB_WDOG_EN
        .wdog_err_o(b3_wdog_err),
`endif
        .grant_o(b3_grant)
    );

    typedef struct {
        int          m;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [31:0] tag;
    } burst_t;

    burst_t mq[NM][$];
    burst_t exp_q[$];
    int     obs_q[$];
    int     errors = 0;
    int     checks = 0;
    int     mptr = 0;

    int     aw_idx[NM], w_idx[NM], w_beat[NM], aw_hold[NM];
    bit     wv[NM];
    int     rdy_pct, wv_pct, exp_rd, beat;
    bit     ph_w;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [BW-1:0] beat_data(input logic [31:0] tag, input int k);
        logic [31:0] kk;
        kk = k;
        return {tag, kk, ~tag, tag ^ 32'h5a5a_5a5a};
    endfunction

    function automatic logic [SW-1:0] beat_strb(input logic [31:0] tag, input int k);
        logic [15:0] t;
        t = 16'(k * 977);
        return tag[15:0] ^ t;
    endfunction

    function automatic burst_t make_burst(input int m, input int len);
        burst_t b;
        b.m = m;  b.id = 4'($urandom);  b.addr = $urandom;  b.len = 8'(len);
        b.size = 3'($urandom);  b.burst = 2'($urandom);  b.tag = $urandom;
        return b;
    endfunction

    // Reference order: every master with pending bursts keeps requesting, so each
    // grant is the nearest pending master at or after the pointer.
    function automatic void model_build();
        int  nxt[NM];
        bit  found;
        int  g;
        foreach (nxt[i]) nxt[i] = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int off = 0; off < NM && !found; off++) begin
                g = (mptr + off) % NM;
                if (nxt[g] < mq[g].size()) begin
                    exp_q.push_back(mq[g][nxt[g]]);
                    nxt[g]++;
                    mptr  = (g + 1) % NM;
                    found = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [31:0] obs_word();
        logic [31:0] w;
        w = '0;
        foreach (obs_q[i]) w = (w << 4) | 32'(obs_q[i]);
        return w;
    endfunction

    task automatic clear_round();
        for (int m = 0; m < NM; m++) begin
            mq[m].delete();
            aw_hold[m] = 0;
        end
        exp_q.delete();
    endtask

    task automatic drive_masters();
        burst_t b;
        for (int m = 0; m < NM; m++) begin
            if (aw_hold[m] == 0 && aw_idx[m] < mq[m].size()) begin
                b = mq[m][aw_idx[m]];
                s_awvalid[m] = 1'b1;
                s_awid[m*IW +: IW]  = b.id;
                s_awaddr[m*32 +: 32] = b.addr;
                s_awlen[m*8 +: 8]   = b.len;
                s_awsize[m*3 +: 3]  = b.size;
                s_awburst[m*2 +: 2] = b.burst;
            end else begin
                s_awvalid[m] = 1'b0;
            end
            if (w_idx[m] < mq[m].size()) begin
                b = mq[m][w_idx[m]];
                if (!wv[m]) wv[m] = ($urandom_range(99) < 32'(wv_pct));
                s_wvalid[m] = wv[m];
                s_wdata[m*BW +: BW] = beat_data(b.tag, w_beat[m]);
                s_wstrb[m*SW +: SW] = beat_strb(b.tag, w_beat[m]);
                s_wlast[m] = (w_beat[m] == int'(b.len));
            end else begin
                s_wvalid[m] = 1'b0;
            end
        end
        m_awready = ($urandom_range(99) < 32'(rdy_pct));
        m_wready  = ($urandom_range(99) < 32'(rdy_pct));
    endtask

    // Per-cycle check of downstream traffic and ready routing against the model
    task automatic compare_cycle();
        logic [NM-1:0] mask;
        burst_t        e;
        bit            have;
        have = (exp_rd < exp_q.size());
        mask = '0;
        if (have) begin
            e = exp_q[exp_rd];
            mask[e.m] = 1'b1;
        end
        chk("awready_only_granted", s_awready & ~mask, 0);
        chk("wready_only_granted", s_wready & ~mask, 0);
        if (ph_w && have) chk("grant_o", grant_o, e.m);
        if (m_awvalid && m_awready) begin
            chk("aw_expected", {have, ph_w}, 2'b10);
            if (have) begin
                chk("m_awid", m_awid, {e.m[1:0], e.id});
                chk("aw_fields", {m_awaddr, m_awlen, m_awsize, m_awburst},
                    {e.addr, e.len, e.size, e.burst});
                chk("aw_source", s_awvalid[e.m] & s_awready[e.m], 1);
                obs_q.push_back(int'(m_awid[5:4]));
                ph_w = 1'b1;
                beat = 0;
            end
        end
        if (m_wvalid && m_wready) begin
            chk("w_expected", {have, ph_w}, 2'b11);
            if (have && ph_w) begin
                chk("m_wdata", m_wdata, beat_data(e.tag, beat));
                chk("m_wstrb", m_wstrb, beat_strb(e.tag, beat));
                chk("m_wlast", m_wlast, beat == int'(e.len));
                chk("w_source", s_wvalid[e.m] & s_wready[e.m], 1);
                beat++;
                if (beat > int'(e.len)) begin
                    ph_w = 1'b0;
                    exp_rd++;
                end
            end
        end
    endtask

    task automatic run_engine(input int max_cycles);
        bit awhs[NM], whs[NM];
        int cyc;
        for (int m = 0; m < NM; m++) begin
            aw_idx[m] = 0;  w_idx[m] = 0;  w_beat[m] = 0;  wv[m] = 1'b0;
        end
        exp_rd = 0;  ph_w = 1'b0;  beat = 0;  cyc = 0;
        obs_q.delete();
        drive_masters();
        while (exp_rd < exp_q.size() && cyc < max_cycles) begin
            @(negedge wclk_i);
            compare_cycle();
            for (int m = 0; m < NM; m++) begin
                awhs[m] = s_awvalid[m] & s_awready[m];
                whs[m]  = s_wvalid[m] & s_wready[m];
            end
            @(posedge wclk_i);
            #1;
            for (int m = 0; m < NM; m++) begin
                if (awhs[m]) aw_idx[m]++;
                if (whs[m]) begin
                    wv[m] = 1'b0;
                    if (w_beat[m] == int'(mq[m][w_idx[m]].len)) begin
                        w_beat[m] = 0;
                        w_idx[m]++;
                    end else begin
                        w_beat[m]++;
                    end
                end
                if (aw_hold[m] > 0) aw_hold[m]--;
            end
            drive_masters();
            cyc++;
        end
        chk("round_complete", exp_rd, exp_q.size());
        s_awvalid = '0;
        s_wvalid  = '0;
        repeat (2) @(posedge wclk_i);
        #1;
    endtask

    task automatic b_check(input logic [5:0] bid, input logic bv, input logic [1:0] br,
                           input logic [3:0] rdy);
        int idx;
        m_bid = bid;  m_bvalid = bv;  m_bresp = br;  s_bready = rdy;
        b3_m_bid = bid;  b3_m_bvalid = bv;  b3_m_bresp = br;  b3_s_bready = rdy[2:0];
        #1;
        idx = int'(bid[5:4]);
        chk("b_valid", s_bvalid, bv ? (4'b0001 << idx) : 4'b0000);
        chk("b_ready", m_bready, rdy[idx]);
        chk("b_id_resp", {s_bid, s_bresp}, {bid[3:0], br});
        chk("b3_valid", b3_s_bvalid, (bv && idx < 3) ? (3'b001 << idx) : 3'b000);
        chk("b3_ready", b3_m_bready, (idx < 3) ? rdy[idx] : 1'b1);
    endtask

    initial begin
        logic [BW-1:0] d1_data;
        int            nb;
        bit            any;

        s_awvalid = '0;  s_awaddr = '0;  s_awid = '0;  s_awlen = '0;  s_awsize = '0;
        s_awburst = '0;  s_wvalid = '0;  s_wdata = '0;  s_wstrb = '0;  s_wlast = '0;
        s_bready = '0;  m_awready = 1'b0;  m_wready = 1'b0;  m_bvalid = 1'b0;
        m_bid = '0;  m_bresp = '0;  b3_m_bid = '0;  b3_m_bvalid = 1'b0;  b3_m_bresp = '0;
        b3_s_bready = '0;
        rdy_pct = 100;  wv_pct = 100;
        for (int m = 0; m < NM; m++) aw_hold[m] = 0;

        repeat (3) @(posedge wclk_i);
        #1;
        chk("rst_m_valids", {m_awvalid, m_wvalid}, 2'b00);
        chk("rst_s_readies", {s_awready, s_wready, s_bvalid}, 0);
        chk("rst_grant", grant_o, 0);
        rrst_n = 1'b1;

        // Single master 0, AWID=3, len=0: AW one cycle after request, IDLE after 3
        @(posedge wclk_i);
        #1;
        d1_data = {32'hdead_beef, 32'h0123_4567, 32'h89ab_cdef, 32'h5555_aaaa};
        s_awvalid[0] = 1'b1;  s_awid[3:0] = 4'd3;  s_awaddr[31:0] = 32'h0000_1000;
        s_awlen[7:0] = 8'd0;  s_awsize[2:0] = 3'd4;  s_awburst[1:0] = 2'd1;
        s_wvalid[0] = 1'b1;  s_wdata[BW-1:0] = d1_data;  s_wstrb[SW-1:0] = 16'hffff;
        s_wlast[0] = 1'b1;  m_awready = 1'b1;  m_wready = 1'b1;
        #3;
        chk("d1_arb_latency", m_awvalid, 0);
        @(posedge wclk_i);
        #1;
        chk("d1_awvalid", m_awvalid, 1);
        chk("d1_awid", m_awid, 6'h03);
        chk("d1_awaddr", m_awaddr, 32'h0000_1000);
        chk("d1_awready", s_awready, 4'b0001);
        @(posedge wclk_i);
        #1;
        s_awvalid[0] = 1'b0;
        chk("d1_wvalid", {m_awvalid, m_wvalid}, 2'b01);
        chk("d1_wready", s_wready, 4'b0001);
        chk("d1_wdata", m_wdata, d1_data);
        @(posedge wclk_i);
        #1;
        s_wvalid[0] = 1'b0;
        chk("d1_back_idle", {m_awvalid, m_wvalid, s_awready, s_wready}, 0);
        mptr = 1;

        // Master 1 presents W beats early while master 2 holds the grant
        clear_round();
        mq[2].push_back(make_burst(2, 1));
        mq[1].push_back(make_burst(1, 2));
        aw_hold[1] = 12;
        exp_q.push_back(mq[2][0]);
        exp_q.push_back(mq[1][0]);
        mptr = 2;
        rdy_pct = 100;  wv_pct = 100;
        run_engine(200);
        chk("d3_grant_order", obs_word(), 32'h21);

        rrst_n = 1'b0;
        @(posedge wclk_i);
        #1;
        rrst_n = 1'b1;
        mptr = 0;

        // Masters 0,1,2 simultaneously with 4-beat bursts
        clear_round();
        for (int m = 0; m < 3; m++) mq[m].push_back(make_burst(m, 3));
        model_build();
        rdy_pct = 70;  wv_pct = 80;
        run_engine(500);
        chk("d2_grant_order", obs_word(), 32'h012);

        // Pointer left at 3: all four requesting starts from master 3
        clear_round();
        for (int m = 0; m < NM; m++) mq[m].push_back(make_burst(m, 0));
        model_build();
        run_engine(500);
        chk("ptr_after_d2", obs_word(), 32'h3012);

        // B routing
        b_check(6'h15, 1'b1, 2'd2, 4'b0010);
        b_check(6'h15, 1'b1, 2'd2, 4'b1101);
        b_check(6'h3a, 1'b1, 2'd1, 4'b0000);
        for (int i = 0; i < 16; i++)
            b_check(6'($urandom), 1'($urandom), 2'($urandom), 4'($urandom));
        m_bvalid = 1'b0;  b3_m_bvalid = 1'b0;

        // Reset during beat 2 of a 4-beat burst from master 2
        s_awvalid[2] = 1'b1;  s_awlen[23:16] = 8'd3;  s_wvalid[2] = 1'b1;  s_wlast[2] = 1'b0;
        m_awready = 1'b1;  m_wready = 1'b1;
        @(posedge wclk_i);
        #1;
        @(posedge wclk_i);
        #1;
        s_awvalid[2] = 1'b0;
        repeat (2) @(posedge wclk_i);
        #1;
        chk("rst_mid_pre", {m_wvalid, grant_o}, 3'b110);
        rrst_n = 1'b0;
        @(posedge wclk_i);
        #1;
        chk("rst_mid_valids", {m_awvalid, m_wvalid}, 2'b00);
        chk("rst_mid_readies", {s_awready, s_wready, s_bvalid}, 0);
        chk("rst_mid_grant", grant_o, 0);
        rrst_n = 1'b1;
        s_wvalid = '0;
        mptr = 0;

        // Randomized rounds
        for (int r = 0; r < 8; r++) begin
            clear_round();
            any = 1'b0;
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(3) != 0) begin
                    nb = int'($urandom_range(3, 1));
                    for (int k = 0; k < nb; k++)
                        mq[m].push_back(make_burst(m, int'($urandom_range(4))));
                    any = 1'b1;
                end
            end
            if (!any) mq[1].push_back(make_burst(1, 2));
            model_build();
            rdy_pct = int'($urandom_range(100, 40));
            wv_pct  = int'($urandom_range(100, 40));
            run_engine(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
